// File: rtl/usb_bus_pkg.sv
// Shared types and constants for the SAM3U external-bus register bridge.
package usb_bus_pkg;

    localparam int DEF_ADDR_WIDTH    = 8;
    localparam int DEF_BYTECNT_SIZE  = 7;
    localparam int DEF_RD_LATENCY    = 2;
    localparam int DEF_STREAM_ADDR   = 3;
    localparam int STROBE_MIN_CYCLES = 4;

    // Bit positions of the strobes inside the synchronizer bus.
    localparam logic [2:0] STB_RD = 3'b001;
    localparam logic [2:0] STB_WR = 3'b010;
    localparam logic [2:0] STB_CE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_DRIVE = 3'd3,
        ST_DONE     = 3'd4
    } bus_state_e;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_FIFO = 2'd1,
        SRC_ZERO = 2'd2
    } rd_src_e;

    function automatic logic strobe_pick(input logic [2:0] vec, input logic [2:0] mask);
        return |(vec & mask);
    endfunction

endpackage

// File: rtl/usb_strobe_sync.sv
// Two-flop synchronizer with rise/fall detection for a bus of asynchronous strobes.
module usb_strobe_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] strobe_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    // Next values of the synchronizer chain and edge-history stage.
    always_comb begin
        meta_d = strobe_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/usb_reg_bridge_burst.sv
// Host strobe to register-pulse bridge with burst byte counter and FIFO streaming reads.
module usb_reg_bridge_burst
    import usb_bus_pkg::*;
#(
    parameter int pADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = DEF_BYTECNT_SIZE,
    parameter int pRD_LATENCY   = DEF_RD_LATENCY,
    parameter int pSTREAM_ADDR  = DEF_STREAM_ADDR
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [pADDR_WIDTH-1:0]   usb_addr,
    input  logic [7:0]               usb_din,
    output logic [7:0]               usb_dout,
    output logic                     usb_isout,
    input  logic                     usb_rdn,
    input  logic                     usb_wrn,
    input  logic                     usb_cen,
    output logic [pADDR_WIDTH-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    output logic                     stream_rd_req,
    input  logic [7:0]               stream_rd_data,
    input  logic                     stream_rd_empty,
    output logic                     stream_underflow
);

    localparam logic [2:0]               LAT_LAST = 3'(pRD_LATENCY);
    localparam logic [pADDR_WIDTH-1:0]   STREAM_A = pADDR_WIDTH'(pSTREAM_ADDR);
    localparam logic [pBYTECNT_SIZE-1:0] BC_MAX   = '1;
    localparam logic [pBYTECNT_SIZE-1:0] BC_ONE   = pBYTECNT_SIZE'(1);

    logic [2:0] sync_s, rise_s, fall_s;
    logic       rd_s, wr_s, cen_s, rd_fall_s, wr_fall_s, rd_rise_s;

    usb_strobe_sync #(.W(3)) u_sync (
        .clk      (clk_usb),
        .rst_n    (reset_n),
        .strobe_i ({usb_cen, usb_wrn, usb_rdn}),
        .sync_o   (sync_s),
        .rise_o   (rise_s),
        .fall_o   (fall_s)
    );

    assign rd_s      = strobe_pick(sync_s, STB_RD);
    assign wr_s      = strobe_pick(sync_s, STB_WR);
    assign cen_s     = strobe_pick(sync_s, STB_CE);
    assign rd_fall_s = strobe_pick(fall_s, STB_RD);
    assign wr_fall_s = strobe_pick(fall_s, STB_WR);
    assign rd_rise_s = strobe_pick(rise_s, STB_RD);

    bus_state_e               state_q, state_d;
    rd_src_e                  src_q, src_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [pBYTECNT_SIZE-1:0] bytecnt_q, bytecnt_d;
    logic [7:0]               datao_q, datao_d, dout_q, dout_d;
    logic [2:0]               lat_q, lat_d;
    logic                     isout_q, isout_d, read_q, read_d, write_q, write_d;
    logic                     sreq_q, sreq_d, uflow_q, uflow_d, valid_q, valid_d;
    logic                     released_q, released_d;

    // Access sequencing: next state and all registered outputs.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        addr_d     = addr_q;
        bytecnt_d  = bytecnt_q;
        datao_d    = datao_q;
        dout_d     = dout_q;
        lat_d      = lat_q;
        isout_d    = isout_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        sreq_d     = 1'b0;
        uflow_d    = uflow_q;
        released_d = released_q;
        case (state_q)
            ST_IDLE: begin
                // Write wins when both strobes fall together.
                if (!cen_s && wr_fall_s) begin
                    addr_d  = usb_addr;
                    datao_d = usb_din;
                    write_d = 1'b1;
                    if (usb_addr != addr_q) begin
                        bytecnt_d = '0;
                    end else begin
                        bytecnt_d = bytecnt_q;
                    end
                    if (usb_addr == STREAM_A) begin
                        uflow_d = 1'b0;
                    end else begin
                        uflow_d = uflow_q;
                    end
                    state_d = ST_WR;
                end else if (!cen_s && rd_fall_s) begin
                    addr_d     = usb_addr;
                    lat_d      = 3'd0;
                    isout_d    = 1'b1;
                    released_d = 1'b0;
                    if (usb_addr != addr_q) begin
                        bytecnt_d = '0;
                    end else begin
                        bytecnt_d = bytecnt_q;
                    end
                    if (usb_addr != STREAM_A) begin
                        src_d  = SRC_REG;
                        read_d = 1'b1;
                    end else if (stream_rd_empty) begin
                        src_d   = SRC_ZERO;
                        uflow_d = 1'b1;
                    end else begin
                        src_d  = SRC_FIFO;
                        sreq_d = 1'b1;
                    end
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
            end
            ST_RD_WAIT: begin
                released_d = released_q | rd_rise_s;
                if (lat_q == LAT_LAST) begin
                    case (src_q)
                        SRC_REG:  dout_d = reg_datai;
                        SRC_FIFO: dout_d = stream_rd_data;
                        default:  dout_d = 8'h00;
                    endcase
                    state_d = ST_RD_DRIVE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_RD_DRIVE: begin
                if (rd_rise_s || released_q) begin
                    isout_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_DRIVE;
                end
            end
            ST_DONE: begin
                if (rd_s && wr_s) begin
                    state_d = ST_IDLE;
                    if ((addr_q != STREAM_A) && (bytecnt_q != BC_MAX)) begin
                        bytecnt_d = bytecnt_q + BC_ONE;
                    end else begin
                        bytecnt_d = bytecnt_q;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                isout_d = 1'b0;
            end
        endcase
        // A deselected chip always starts the next burst at byte 0.
        if (cen_s) begin
            bytecnt_d = '0;
        end else begin
            bytecnt_d = bytecnt_d;
        end
        valid_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_REG;
            addr_q     <= '0;
            bytecnt_q  <= '0;
            datao_q    <= 8'h00;
            dout_q     <= 8'h00;
            lat_q      <= 3'd0;
            isout_q    <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            sreq_q     <= 1'b0;
            uflow_q    <= 1'b0;
            valid_q    <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            bytecnt_q  <= bytecnt_d;
            datao_q    <= datao_d;
            dout_q     <= dout_d;
            lat_q      <= lat_d;
            isout_q    <= isout_d;
            read_q     <= read_d;
            write_q    <= write_d;
            sreq_q     <= sreq_d;
            uflow_q    <= uflow_d;
            valid_q    <= valid_d;
            released_q <= released_d;
        end
    end

    assign usb_dout         = dout_q;
    assign usb_isout        = isout_q;
    assign reg_address      = addr_q;
    assign reg_bytecnt      = bytecnt_q;
    assign reg_datao        = datao_q;
    assign reg_read         = read_q;
    assign reg_write        = write_q;
    assign reg_addrvalid    = valid_q;
    assign stream_rd_req    = sreq_q;
    assign stream_underflow = uflow_q;

endmodule

// File: tb/tb_usb_reg_bridge_burst.sv
// Randomized bench for usb_reg_bridge_burst against a transaction-level reference model.
module tb_usb_reg_bridge_burst;
    import usb_bus_pkg::*;

    localparam int LAT   = 5;
    localparam int BCW   = 2;
    localparam int SADDR = 3;
    localparam int BCMAX = (1 << BCW) - 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [7:0]     usb_addr, usb_din, usb_dout;
    logic           usb_isout, usb_rdn, usb_wrn, usb_cen;
    logic [7:0]     reg_address, reg_datao, reg_datai;
    logic [BCW-1:0] reg_bytecnt;
    logic           reg_read, reg_write, reg_addrvalid;
    logic           stream_rd_req, stream_rd_empty, stream_underflow;
    logic [7:0]     stream_rd_data;

    always #5 clk = ~clk;

    usb_reg_bridge_burst #(
        .pADDR_WIDTH(8), .pBYTECNT_SIZE(BCW), .pRD_LATENCY(LAT), .pSTREAM_ADDR(SADDR)
    ) dut (
        .clk_usb(clk), .reset_n(reset_n), .usb_addr(usb_addr), .usb_din(usb_din),
        .usb_dout(usb_dout), .usb_isout(usb_isout), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn),
        .usb_cen(usb_cen), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_datao(reg_datao), .reg_datai(reg_datai), .reg_read(reg_read),
        .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .stream_rd_req(stream_rd_req),
        .stream_rd_data(stream_rd_data), .stream_rd_empty(stream_rd_empty),
        .stream_underflow(stream_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register file behaviour: contents depend on address and byte index.
    function automatic logic [7:0] reg_resp(input logic [7:0] a, input logic [BCW-1:0] b);
        return {a[3:0], 4'h0} ^ 8'h50 ^ 8'(b);
    endfunction

    // Peripheral side: answers requests exactly LAT cycles later, junk otherwise.
    logic [7:0]     hw_q[$];
    int             cyc = 0, pend_r = -100, pend_s = -100;
    logic [7:0]     pend_r_val = 8'h00, pend_s_val = 8'h00;
    int             n_rd = 0, n_wr = 0, n_sr = 0;
    logic [7:0]     snap_addr = 8'h00, snap_datao = 8'h00;
    logic [BCW-1:0] snap_bc = '0;

    always @(negedge clk) begin
        cyc++;
        if (reg_read === 1'b1) begin
            n_rd++;
            pend_r     = cyc + LAT;
            pend_r_val = reg_resp(reg_address, reg_bytecnt);
        end
        if (stream_rd_req === 1'b1) begin
            n_sr++;
            pend_s     = cyc + LAT;
            pend_s_val = (hw_q.size() > 0) ? hw_q.pop_front() : 8'hEE;
        end
        if (reg_write === 1'b1) begin
            n_wr++;
            snap_addr  = reg_address;
            snap_datao = reg_datao;
            snap_bc    = reg_bytecnt;
        end
        reg_datai       = (cyc == pend_r) ? pend_r_val : 8'hEE;
        stream_rd_data  = (cyc == pend_s) ? pend_s_val : 8'hEE;
        stream_rd_empty = (hw_q.size() == 0);
    end

    // Reference model of the bus-visible state.
    logic [7:0] exp_q[$];
    logic [7:0] m_addr  = 8'h00;
    int         m_bc    = 0;
    bit         m_uflow = 1'b0;

    task automatic fifo_push(input logic [7:0] v);
        hw_q.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic select_chip();
        if (usb_cen) begin
            usb_cen = 1'b0;
            repeat (STROBE_MIN_CYCLES) @(negedge clk);
        end
    endtask

    task automatic finish_access(input logic [7:0] a, input bit keep_cen);
        if (a != 8'(SADDR) && m_bc < BCMAX) m_bc++;
        chk("bytecnt_after", 32'(reg_bytecnt), 32'(m_bc));
        if (!keep_cen) begin
            usb_cen = 1'b1;
            repeat (4) @(negedge clk);
            m_bc = 0;
            chk("cen_clear", 32'(reg_bytecnt), 32'd0);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input bit keep_cen, input int hold);
        logic [7:0] exp_d;
        int exp_bc, exp_nrd, exp_nsr, rd0, sr0;
        if (a != m_addr) m_bc = 0;
        m_addr = a;
        exp_bc = m_bc;
        if (a == 8'(SADDR)) begin
            exp_nrd = 0;
            if (exp_q.size() == 0) begin
                exp_d = 8'h00; exp_nsr = 0; m_uflow = 1'b1;
            end else begin
                exp_d = exp_q.pop_front(); exp_nsr = 1;
            end
        end else begin
            exp_nrd = 1; exp_nsr = 0;
            exp_d = reg_resp(a, exp_bc[BCW-1:0]);
        end
        select_chip();
        usb_addr = a;
        rd0 = n_rd;
        sr0 = n_sr;
        usb_rdn = 1'b0;
        repeat (hold) @(negedge clk);
        chk("rd_bytecnt", 32'(reg_bytecnt), 32'(exp_bc));
        chk("rd_address", 32'(reg_address), 32'(a));
        chk("rd_addrvalid", 32'(reg_addrvalid), 32'd1);
        if (hold >= 14) begin
            chk("rd_isout", 32'(usb_isout), 32'd1);
            chk("rd_dout", 32'(usb_dout), 32'(exp_d));
        end
        usb_rdn = 1'b1;
        repeat (12) @(negedge clk);
        chk("rd_isout_off", 32'(usb_isout), 32'd0);
        chk("rd_idle", 32'(reg_addrvalid), 32'd0);
        chk("rd_pulses", 32'(n_rd - rd0), 32'(exp_nrd));
        chk("pop_pulses", 32'(n_sr - sr0), 32'(exp_nsr));
        chk("rd_underflow", 32'(stream_underflow), 32'(m_uflow));
        finish_access(a, keep_cen);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit keep_cen);
        int exp_bc, wr0;
        if (a != m_addr) m_bc = 0;
        m_addr = a;
        exp_bc = m_bc;
        if (a == 8'(SADDR)) m_uflow = 1'b0;
        select_chip();
        usb_addr = a;
        usb_din  = d;
        wr0 = n_wr;
        usb_wrn = 1'b0;
        repeat (8) @(negedge clk);
        usb_wrn = 1'b1;
        repeat (12) @(negedge clk);
        chk("wr_pulses", 32'(n_wr - wr0), 32'd1);
        chk("wr_address", 32'(snap_addr), 32'(a));
        chk("wr_datao", 32'(snap_datao), 32'(d));
        chk("wr_bytecnt", 32'(snap_bc), 32'(exp_bc));
        chk("wr_underflow", 32'(stream_underflow), 32'(m_uflow));
        chk("wr_idle", 32'(reg_addrvalid), 32'd0);
        finish_access(a, keep_cen);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; usb_rdn = 1'b0; usb_wrn = 1'b1; usb_cen = 1'b0;
        usb_addr = 8'h00; usb_din = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_isout", 32'(usb_isout), 32'd0);
        chk("rst_read", 32'(reg_read), 32'd0);
        chk("rst_write", 32'(reg_write), 32'd0);
        chk("rst_dout", 32'(usb_dout), 32'd0);
        chk("rst_bytecnt", 32'(reg_bytecnt), 32'd0);
        usb_rdn = 1'b1; usb_cen = 1'b1; reset_n = 1'b1;
        repeat (5) @(negedge clk);

        do_write(8'h01, 8'hA5, 1'b0);

        for (int i = 0; i < 4; i++) do_read(8'h04, (i < 3), 16);
        for (int i = 0; i < 6; i++) do_read(8'h06, (i < 5), 16);

        fifo_push(8'h3C); fifo_push(8'h3D); fifo_push(8'h3E);
        for (int i = 0; i < 4; i++) do_read(8'(SADDR), 1'b1, 16);
        do_write(8'(SADDR), 8'h00, 1'b0);

        // Reset in the middle of a read wait.
        usb_cen = 1'b0;
        repeat (4) @(negedge clk);
        usb_addr = 8'h04;
        usb_rdn  = 1'b0;
        k = 0;
        while (reg_read !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mr_read_seen", 32'(k < 20), 32'd1);
        @(negedge clk);
        chk("mr_isout_on", 32'(usb_isout), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_isout_off", 32'(usb_isout), 32'd0);
        chk("mr_bytecnt", 32'(reg_bytecnt), 32'd0);
        chk("mr_addrvalid", 32'(reg_addrvalid), 32'd0);
        repeat (3) @(negedge clk);
        usb_rdn = 1'b1; usb_cen = 1'b1; reset_n = 1'b1;
        repeat (5) @(negedge clk);
        m_bc = 0; m_addr = 8'h00; m_uflow = 1'b0;
        do_read(8'h04, 1'b0, 16);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            bit keep;
            int hold;
            a    = 8'($urandom_range(1, 6));
            keep = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 4) == 0) ? STROBE_MIN_CYCLES + int'($urandom_range(0, 3)) : 16;
            if ($urandom_range(0, 3) == 0) fifo_push(8'($urandom));
            if ($urandom_range(0, 1) == 0) do_write(a, 8'($urandom), keep);
            else do_read(a, keep, hold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
